// File: rtl/csr_to_banked_ram_bridge.sv
// csr_to_banked_ram_bridge
// Bridges single-cycle CSR-style read/write requests onto a set of banked
// synchronous RAMs that share one address/data bus with a per-bank write
// enable. Byte addresses are decoded into bank and word; banks beyond
// NUM_BANKS answer immediately with an error ack.
//
// Optional feature: define CSR_TO_BANKED_RAM_BRIDGE_RMW_EN to turn writes
// with partially bit-enabled bytes into read-modify-write sequences. When it
// is undefined, any enabled bit makes the whole byte writable.
//
// Reset release is synchronised internally with a two-flop chain; assertion
// clears every register immediately.

module csr_to_banked_ram_bridge #(
    parameter int WORD_BIT_WIDTH = 32,
    parameter int BANK_DEPTH     = 8,
    parameter int NUM_BANKS      = 2,
    parameter int RAM_RD_LATENCY = 1,
    localparam int BPW  = WORD_BIT_WIDTH / 8,
    localparam int BA_W = $clog2(NUM_BANKS * BANK_DEPTH * BPW),
    localparam int WA_W = $clog2(BANK_DEPTH)
) (
    input  logic                                i_clk,
    input  logic                                i_async_rst_n,
    input  logic                                i_acc_req,
    input  logic                                i_acc_req_is_wr,
    input  logic [BA_W-1:0]                     i_byte_addr,
    input  logic [WORD_BIT_WIDTH-1:0]           i_wr_data,
    input  logic [WORD_BIT_WIDTH-1:0]           i_wr_bit_en,
    output logic                                o_rd_ack,
    output logic                                o_wr_ack,
    output logic [WORD_BIT_WIDTH-1:0]           o_rd_data,
    output logic                                o_err,
    output logic                                o_busy,
    output logic [NUM_BANKS-1:0]                o_ram_we,
    output logic [WA_W-1:0]                     o_ram_word_addr,
    output logic [WORD_BIT_WIDTH-1:0]           o_ram_wr_data,
    output logic [BPW-1:0]                      o_ram_wr_byte_en,
    input  logic [NUM_BANKS*WORD_BIT_WIDTH-1:0] i_ram_rd_data
);

    localparam int OFF_W = $clog2(BPW);
    localparam int BK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [1:0] LAT_M1 = 2'(RAM_RD_LATENCY - 1);

`ifdef CSR_TO_BANKED_RAM_BRIDGE_RMW_EN
    localparam bit RMW_EN = 1'b1;
`else
    localparam bit RMW_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR      = 3'd3,
        ST_ACK     = 3'd4
    } state_t;

    // Per-byte enable: a byte is written if any of its bits is enabled.
    function automatic logic [BPW-1:0] byte_en_of(input logic [WORD_BIT_WIDTH-1:0] bits);
        logic [BPW-1:0] r;
        r = {BPW{1'b0}};
        for (int b = 0; b < BPW; b++) begin
            r[b] = |bits[8*b +: 8];
        end
        return r;
    endfunction

    // True when at least one byte has some, but not all, bits enabled.
    function automatic logic has_partial_byte(input logic [WORD_BIT_WIDTH-1:0] bits);
        logic r;
        r = 1'b0;
        for (int b = 0; b < BPW; b++) begin
            r = r | ((|bits[8*b +: 8]) & ~(&bits[8*b +: 8]));
        end
        return r;
    endfunction

    // One-hot write-enable vector for a bank index.
    function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [BK_W-1:0] idx);
        logic [NUM_BANKS-1:0] r;
        r = {NUM_BANKS{1'b0}};
        for (int i = 0; i < NUM_BANKS; i++) begin
            r[i] = (idx == BK_W'(i));
        end
        return r;
    endfunction

    // Reset synchroniser and internal reset
    logic [1:0] rst_sync_q;
    logic       rst_n_s;

    // Request decode
    logic [BA_W-1:0] req_bank_s;
    logic [BK_W-1:0] req_bank_idx_s;
    logic [WA_W-1:0] req_local_s;
    logic            req_oor_s;
    logic            req_rmw_s;

    // FSM and latched request
    state_t                    state_q, state_d;
    logic [1:0]                wait_cnt_q, wait_cnt_d;
    logic [BK_W-1:0]           bank_q, bank_d;
    logic                      is_wr_q, is_wr_d;
    logic [WORD_BIT_WIDTH-1:0] bit_en_q, bit_en_d;
    logic [WORD_BIT_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [WORD_BIT_WIDTH-1:0] rd_word_s;

    // Registered outputs
    logic                      rd_ack_q, rd_ack_d;
    logic                      wr_ack_q, wr_ack_d;
    logic                      err_q, err_d;
    logic                      busy_q, busy_d;
    logic [WORD_BIT_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [NUM_BANKS-1:0]      ram_we_q, ram_we_d;
    logic [WA_W-1:0]           word_addr_q, word_addr_d;
    logic [WORD_BIT_WIDTH-1:0] ram_wr_data_q, ram_wr_data_d;
    logic [BPW-1:0]            byte_en_q, byte_en_d;

    assign req_bank_s     = i_byte_addr >> (OFF_W + WA_W);
    assign req_bank_idx_s = req_bank_s[BK_W-1:0];
    assign req_local_s    = i_byte_addr[OFF_W +: WA_W];
    assign req_oor_s      = (req_bank_s >= BA_W'(NUM_BANKS));
    assign req_rmw_s      = RMW_EN & has_partial_byte(i_wr_bit_en);
    assign rd_word_s      = i_ram_rd_data[bank_q*WORD_BIT_WIDTH +: WORD_BIT_WIDTH];
    assign rst_n_s        = rst_sync_q[1];

    // Two-flop reset synchroniser: asserts immediately, releases on i_clk.
    always_ff @(posedge i_clk or negedge i_async_rst_n) begin
        if (!i_async_rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // FSM next-state logic; requests are only looked at in IDLE.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_acc_req) begin
                    if (req_oor_s) begin
                        state_d = ST_ACK;
                    end else if (i_acc_req_is_wr && !req_rmw_s) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                state_d    = ST_RD_WAIT;
                wait_cnt_d = LAT_M1;
            end
            ST_RD_WAIT: begin
                if (wait_cnt_q == 2'd0) begin
                    if (is_wr_q) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_ACK;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - 2'd1;
                end
            end
            ST_WR:   state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values, registered one cycle ahead of use.
    always_comb begin
        rd_ack_d      = 1'b0;
        wr_ack_d      = 1'b0;
        err_d         = 1'b0;
        busy_d        = (state_d != ST_IDLE);
        ram_we_d      = {NUM_BANKS{1'b0}};
        byte_en_d     = {BPW{1'b0}};
        rd_data_d     = rd_data_q;
        word_addr_d   = word_addr_q;
        ram_wr_data_d = ram_wr_data_q;
        bank_d        = bank_q;
        is_wr_d       = is_wr_q;
        bit_en_d      = bit_en_q;
        wr_data_d     = wr_data_q;
        case (state_q)
            ST_IDLE: begin
                if (i_acc_req) begin
                    bank_d      = req_bank_idx_s;
                    is_wr_d     = i_acc_req_is_wr;
                    bit_en_d    = i_wr_bit_en;
                    wr_data_d   = i_wr_data;
                    word_addr_d = req_local_s;
                    if (req_oor_s) begin
                        err_d = 1'b1;
                        if (i_acc_req_is_wr) begin
                            wr_ack_d = 1'b1;
                        end else begin
                            rd_ack_d  = 1'b1;
                            rd_data_d = {WORD_BIT_WIDTH{1'b0}};
                        end
                    end else if (i_acc_req_is_wr && !req_rmw_s) begin
                        ram_we_d      = bank_onehot(req_bank_idx_s);
                        byte_en_d     = byte_en_of(i_wr_bit_en);
                        ram_wr_data_d = i_wr_data;
                    end else begin
                        ram_we_d = {NUM_BANKS{1'b0}};
                    end
                end else begin
                    ram_we_d = {NUM_BANKS{1'b0}};
                end
            end
            ST_RD_WAIT: begin
                if (wait_cnt_q == 2'd0) begin
                    if (is_wr_q) begin
                        // Merge new bits into the word just read back.
                        ram_wr_data_d = (rd_word_s & ~bit_en_q) | (wr_data_q & bit_en_q);
                        byte_en_d     = {BPW{1'b1}};
                        ram_we_d      = bank_onehot(bank_q);
                    end else begin
                        rd_data_d = rd_word_s;
                        rd_ack_d  = 1'b1;
                    end
                end else begin
                    ram_we_d = {NUM_BANKS{1'b0}};
                end
            end
            ST_WR: begin
                wr_ack_d = 1'b1;
            end
            ST_RD, ST_ACK: begin
                ram_we_d = {NUM_BANKS{1'b0}};
            end
            default: begin
                ram_we_d = {NUM_BANKS{1'b0}};
            end
        endcase
    end

    // Output and request-latch registers.
    always_ff @(posedge i_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            rd_ack_q      <= 1'b0;
            wr_ack_q      <= 1'b0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
            rd_data_q     <= {WORD_BIT_WIDTH{1'b0}};
            ram_we_q      <= {NUM_BANKS{1'b0}};
            word_addr_q   <= {WA_W{1'b0}};
            ram_wr_data_q <= {WORD_BIT_WIDTH{1'b0}};
            byte_en_q     <= {BPW{1'b0}};
            bank_q        <= {BK_W{1'b0}};
            is_wr_q       <= 1'b0;
            bit_en_q      <= {WORD_BIT_WIDTH{1'b0}};
            wr_data_q     <= {WORD_BIT_WIDTH{1'b0}};
        end else begin
            rd_ack_q      <= rd_ack_d;
            wr_ack_q      <= wr_ack_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
            rd_data_q     <= rd_data_d;
            ram_we_q      <= ram_we_d;
            word_addr_q   <= word_addr_d;
            ram_wr_data_q <= ram_wr_data_d;
            byte_en_q     <= byte_en_d;
            bank_q        <= bank_d;
            is_wr_q       <= is_wr_d;
            bit_en_q      <= bit_en_d;
            wr_data_q     <= wr_data_d;
        end
    end

    assign o_rd_ack         = rd_ack_q;
    assign o_wr_ack         = wr_ack_q;
    assign o_err            = err_q;
    assign o_busy           = busy_q;
    assign o_rd_data        = rd_data_q;
    assign o_ram_we         = ram_we_q;
    assign o_ram_word_addr  = word_addr_q;
    assign o_ram_wr_data    = ram_wr_data_q;
    assign o_ram_wr_byte_en = byte_en_q;

endmodule

// File: tb/tb_csr_to_banked_ram_bridge.sv
// Directed self-checking bench for csr_to_banked_ram_bridge with
// WORD=32, BANK_DEPTH=8, NUM_BANKS=3, RAM_RD_LATENCY=1 (BA_W=7).
// A behavioural latency-1 banked RAM sits behind the bridge.

module tb_csr_to_banked_ram_bridge;

    logic        clk;
    logic        rst_n;
    logic        acc_req;
    logic        is_wr;
    logic [6:0]  byte_addr;
    logic [31:0] wr_data;
    logic [31:0] bit_en;
    logic        rd_ack;
    logic        wr_ack;
    logic [31:0] rd_data;
    logic        err;
    logic        busy;
    logic [2:0]  ram_we;
    logic [2:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic [95:0] ram_rd;

    logic [31:0] mem [3][8];
    logic [31:0] last_rd;

    int checks;
    int failures;

    csr_to_banked_ram_bridge #(
        .WORD_BIT_WIDTH(32),
        .BANK_DEPTH(8),
        .NUM_BANKS(3),
        .RAM_RD_LATENCY(1)
    ) dut (
        .i_clk(clk),
        .i_async_rst_n(rst_n),
        .i_acc_req(acc_req),
        .i_acc_req_is_wr(is_wr),
        .i_byte_addr(byte_addr),
        .i_wr_data(wr_data),
        .i_wr_bit_en(bit_en),
        .o_rd_ack(rd_ack),
        .o_wr_ack(wr_ack),
        .o_rd_data(rd_data),
        .o_err(err),
        .o_busy(busy),
        .o_ram_we(ram_we),
        .o_ram_word_addr(ram_addr),
        .o_ram_wr_data(ram_wdata),
        .o_ram_wr_byte_en(ram_be),
        .i_ram_rd_data(ram_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural banked RAM: one-cycle read latency, byte-enabled writes.
    always @(posedge clk) begin
        for (int b = 0; b < 3; b++) begin
            ram_rd[b*32 +: 32] <= mem[b][ram_addr];
            if (ram_we[b]) begin
                for (int k = 0; k < 4; k++) begin
                    if (ram_be[k]) mem[b][ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
                end
            end
        end
    end

    // Issues one request and records what happens over the next 12 cycles.
    // Cycle c is observed at the c-th falling edge after the request cycle.
    task automatic run_access(input logic wr, input logic [6:0] addr,
                              input logic [31:0] data, input logic [31:0] ben,
                              input logic dup,
                              output int ack_cyc, output int n_acks,
                              output logic ack_is_wr, output logic ack_err,
                              output logic [31:0] ack_rdata,
                              output int we_cyc, output logic [2:0] we_val,
                              output logic [2:0] wa_val, output logic [3:0] be_val,
                              output logic [31:0] wd_val, output int multi_we,
                              output logic busy1);
        ack_cyc = -1; n_acks = 0; ack_is_wr = 1'b0; ack_err = 1'b0; ack_rdata = 32'd0;
        we_cyc = -1; we_val = 3'd0; wa_val = 3'd0; be_val = 4'd0; wd_val = 32'd0;
        multi_we = 0; busy1 = 1'b0;
        @(negedge clk);
        acc_req = 1'b1; is_wr = wr; byte_addr = addr; wr_data = data; bit_en = ben;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (!(dup && c == 1)) acc_req = 1'b0;
            if (c == 1) busy1 = busy;
            if (rd_ack || wr_ack) begin
                n_acks++;
                if (ack_cyc < 0) begin
                    ack_cyc = c; ack_is_wr = wr_ack; ack_err = err; ack_rdata = rd_data;
                end
            end
            if (ram_we != 3'd0) begin
                if ($countones(ram_we) > 1) multi_we++;
                if (we_cyc < 0) begin
                    we_cyc = c; we_val = ram_we; wa_val = ram_addr; be_val = ram_be; wd_val = ram_wdata;
                end
            end
        end
    endtask

    int          a_cyc, n_ack, w_cyc, m_we;
    logic        a_wr, a_err, b1;
    logic [31:0] a_rd, w_d;
    logic [2:0]  w_v, w_a;
    logic [3:0]  w_b;

    task automatic test_reset();
        rst_n = 1'b0; acc_req = 1'b0; is_wr = 1'b0; byte_addr = 7'd0;
        wr_data = 32'd0; bit_en = 32'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rd_ack, wr_ack, err, busy, ram_we, ram_be} !== 11'd0) begin
            failures++; $display("FAIL reset_ctrl: got %b expected 0", {rd_ack, wr_ack, err, busy, ram_we, ram_be});
        end
        checks++;
        if (rd_data !== 32'd0) begin failures++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
        checks++;
        if ({ram_addr, ram_wdata} !== 35'd0) begin failures++; $display("FAIL reset_bus: got %h expected 0", {ram_addr, ram_wdata}); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
    endtask

    task automatic test_write_full();
        run_access(1'b1, 7'h24, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b0, a_cyc, n_ack, a_wr, a_err, a_rd, w_cyc, w_v, w_a, w_b, w_d, m_we, b1);
        checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL wr_busy: got %b expected 1", b1); end
        checks++; if (w_cyc != 1) begin failures++; $display("FAIL wr_we_cycle: got %0d expected 1", w_cyc); end
        checks++; if (w_v !== 3'b010) begin failures++; $display("FAIL wr_we: got %b expected 010", w_v); end
        checks++; if (w_a !== 3'd1) begin failures++; $display("FAIL wr_word_addr: got %0d expected 1", w_a); end
        checks++; if (w_b !== 4'hF) begin failures++; $display("FAIL wr_byte_en: got %h expected f", w_b); end
        checks++; if (w_d !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_data: got %h expected deadbeef", w_d); end
        checks++; if (a_cyc != 2 || a_wr !== 1'b1) begin failures++; $display("FAIL wr_ack: got cyc %0d wr %b expected cyc 2 wr 1", a_cyc, a_wr); end
        checks++; if (a_err !== 1'b0 || n_ack != 1 || m_we != 0) begin failures++; $display("FAIL wr_err_count: got err %b acks %0d multi %0d expected 0 1 0", a_err, n_ack, m_we); end
    endtask

    task automatic test_read();
        run_access(1'b0, 7'h24, 32'd0, 32'd0, 1'b0, a_cyc, n_ack, a_wr, a_err, a_rd, w_cyc, w_v, w_a, w_b, w_d, m_we, b1);
        checks++; if (a_cyc != 3 || a_wr !== 1'b0) begin failures++; $display("FAIL rd_ack: got cyc %0d wr %b expected cyc 3 wr 0", a_cyc, a_wr); end
        checks++; if (a_rd !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data: got %h expected deadbeef", a_rd); end
        checks++; if (a_err !== 1'b0 || n_ack != 1 || w_cyc != -1) begin failures++; $display("FAIL rd_misc: got err %b acks %0d we_cyc %0d expected 0 1 -1", a_err, n_ack, w_cyc); end
        last_rd = 32'hDEADBEEF;
    endtask

    task automatic test_out_of_range();
        run_access(1'b0, 7'h60, 32'd0, 32'd0, 1'b0, a_cyc, n_ack, a_wr, a_err, a_rd, w_cyc, w_v, w_a, w_b, w_d, m_we, b1);
        checks++; if (a_cyc != 1 || a_wr !== 1'b0 || a_err !== 1'b1) begin failures++; $display("FAIL oor_rd_ack: got cyc %0d wr %b err %b expected 1 0 1", a_cyc, a_wr, a_err); end
        checks++; if (a_rd !== 32'd0 || w_cyc != -1 || n_ack != 1) begin failures++; $display("FAIL oor_rd_misc: got data %h we_cyc %0d acks %0d expected 0 -1 1", a_rd, w_cyc, n_ack); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL oor_err_clear: got %b expected 0", err); end
        run_access(1'b1, 7'h7C, 32'h55555555, 32'hFFFFFFFF, 1'b0, a_cyc, n_ack, a_wr, a_err, a_rd, w_cyc, w_v, w_a, w_b, w_d, m_we, b1);
        checks++; if (a_cyc != 1 || a_wr !== 1'b1 || a_err !== 1'b1 || w_cyc != -1) begin failures++; $display("FAIL oor_wr: got cyc %0d wr %b err %b we_cyc %0d expected 1 1 1 -1", a_cyc, a_wr, a_err, w_cyc); end
        checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL oor_rd_hold: got %h expected 0", rd_data); end
        last_rd = 32'd0;
        // Top in-range word, with byte-offset bits set on the write.
        run_access(1'b1, 7'h5F, 32'hCAFEF00D, 32'hFFFFFFFF, 1'b0, a_cyc, n_ack, a_wr, a_err, a_rd, w_cyc, w_v, w_a, w_b, w_d, m_we, b1);
        checks++; if (w_v !== 3'b100 || w_a !== 3'd7 || a_err !== 1'b0) begin failures++; $display("FAIL top_wr: got we %b addr %0d err %b expected 100 7 0", w_v, w_a, a_err); end
        run_access(1'b0, 7'h5C, 32'd0, 32'd0, 1'b0, a_cyc, n_ack, a_wr, a_err, a_rd, w_cyc, w_v, w_a, w_b, w_d, m_we, b1);
        checks++; if (a_rd !== 32'hCAFEF00D || a_cyc != 3) begin failures++; $display("FAIL top_rd: got %h cyc %0d expected cafef00d 3", a_rd, a_cyc); end
        last_rd = 32'hCAFEF00D;
    endtask

    task automatic test_byte_enables();
        run_access(1'b1, 7'h14, 32'h11111111, 32'hFFFFFFFF, 1'b0, a_cyc, n_ack, a_wr, a_err, a_rd, w_cyc, w_v, w_a, w_b, w_d, m_we, b1);
        checks++; if (w_v !== 3'b001 || w_a !== 3'd5) begin failures++; $display("FAIL be_init_wr: got we %b addr %0d expected 001 5", w_v, w_a); end
        run_access(1'b1, 7'h14, 32'hAABBCCDD, 32'hFF00FF00, 1'b0, a_cyc, n_ack, a_wr, a_err, a_rd, w_cyc, w_v, w_a, w_b, w_d, m_we, b1);
        checks++; if (w_b !== 4'b1010 || w_cyc != 1 || a_cyc != 2) begin failures++; $display("FAIL be_mask: got be %b we_cyc %0d ack %0d expected 1010 1 2", w_b, w_cyc, a_cyc); end
        checks++; if (rd_data !== last_rd) begin failures++; $display("FAIL be_rd_hold: got %h expected %h", rd_data, last_rd); end
        run_access(1'b0, 7'h14, 32'd0, 32'd0, 1'b0, a_cyc, n_ack, a_wr, a_err, a_rd, w_cyc, w_v, w_a, w_b, w_d, m_we, b1);
        checks++; if (a_rd !== 32'hAA11CC11) begin failures++; $display("FAIL be_readback: got %h expected aa11cc11", a_rd); end
        last_rd = 32'hAA11CC11;
    endtask

    task automatic test_partial();
        logic [31:0] exp_word;
        int          exp_ack;
        int          exp_we_cyc;
        logic [3:0]  exp_be;
`ifdef CSR_TO_BANKED_RAM_BRIDGE_RMW_EN
        exp_word = 32'h123456A8; exp_ack = 4; exp_we_cyc = 3; exp_be = 4'hF;
`else
        exp_word = 32'h123456A0; exp_ack = 2; exp_we_cyc = 1; exp_be = 4'h1;
`endif
        run_access(1'b1, 7'h4C, 32'h12345678, 32'hFFFFFFFF, 1'b0, a_cyc, n_ack, a_wr, a_err, a_rd, w_cyc, w_v, w_a, w_b, w_d, m_we, b1);
        run_access(1'b1, 7'h4C, 32'h000000A0, 32'h000000F0, 1'b0, a_cyc, n_ack, a_wr, a_err, a_rd, w_cyc, w_v, w_a, w_b, w_d, m_we, b1);
        checks++; if (a_cyc != exp_ack || a_wr !== 1'b1 || n_ack != 1) begin failures++; $display("FAIL part_ack: got cyc %0d wr %b acks %0d expected %0d 1 1", a_cyc, a_wr, n_ack, exp_ack); end
        checks++; if (w_cyc != exp_we_cyc || w_b !== exp_be || w_v !== 3'b100 || w_a !== 3'd3) begin failures++; $display("FAIL part_we: got cyc %0d be %h we %b addr %0d expected %0d %h 100 3", w_cyc, w_b, w_v, w_a, exp_we_cyc, exp_be); end
        run_access(1'b0, 7'h4C, 32'd0, 32'd0, 1'b0, a_cyc, n_ack, a_wr, a_err, a_rd, w_cyc, w_v, w_a, w_b, w_d, m_we, b1);
        checks++; if (a_rd !== exp_word) begin failures++; $display("FAIL part_readback: got %h expected %h", a_rd, exp_word); end
        last_rd = exp_word;
    endtask

    task automatic test_back_to_back();
        int          k_ack;
        logic [31:0] k_data;
        k_ack = -1; k_data = 32'd0;
        @(negedge clk);
        acc_req = 1'b1; is_wr = 1'b1; byte_addr = 7'h08; wr_data = 32'h5A5A5A5A; bit_en = 32'hFFFFFFFF;
        @(negedge clk); acc_req = 1'b0;
        @(negedge clk);
        checks++; if (wr_ack !== 1'b1) begin failures++; $display("FAIL b2b_wr_ack: got %b expected 1", wr_ack); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle: got busy %b expected 0", busy); end
        acc_req = 1'b1; is_wr = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            acc_req = 1'b0;
            if (rd_ack && k_ack < 0) begin k_ack = k; k_data = rd_data; end
        end
        checks++; if (k_ack != 3 || k_data !== 32'h5A5A5A5A) begin failures++; $display("FAIL b2b_rd: got cyc %0d data %h expected 3 5a5a5a5a", k_ack, k_data); end
        last_rd = 32'h5A5A5A5A;
    endtask

    task automatic test_drop();
        run_access(1'b0, 7'h24, 32'd0, 32'd0, 1'b1, a_cyc, n_ack, a_wr, a_err, a_rd, w_cyc, w_v, w_a, w_b, w_d, m_we, b1);
        checks++; if (n_ack != 1 || a_cyc != 3) begin failures++; $display("FAIL drop_acks: got acks %0d cyc %0d expected 1 3", n_ack, a_cyc); end
        checks++; if (a_rd !== 32'hDEADBEEF) begin failures++; $display("FAIL drop_data: got %h expected deadbeef", a_rd); end
        last_rd = 32'hDEADBEEF;
    endtask

    task automatic test_reset_mid();
        int acks;
        acks = 0;
        @(negedge clk);
        acc_req = 1'b1; is_wr = 1'b0; byte_addr = 7'h4C;
        @(negedge clk);
        acc_req = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy: got %b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rd_ack, wr_ack, err, busy, ram_we, ram_be} !== 11'd0 || {ram_addr, ram_wdata} !== 35'd0) begin
            failures++; $display("FAIL mid_reset_outs: got %b %h expected 0", {rd_ack, wr_ack, err, busy, ram_we, ram_be}, {ram_addr, ram_wdata});
        end
        checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL mid_reset_rd_data: got %h expected 0", rd_data); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rd_ack || wr_ack) acks++;
        end
        checks++; if (acks != 0) begin failures++; $display("FAIL mid_no_ack: got %0d acks expected 0", acks); end
        run_access(1'b0, 7'h24, 32'd0, 32'd0, 1'b0, a_cyc, n_ack, a_wr, a_err, a_rd, w_cyc, w_v, w_a, w_b, w_d, m_we, b1);
        checks++; if (a_cyc != 3 || a_rd !== 32'hDEADBEEF) begin failures++; $display("FAIL mid_recover: got cyc %0d data %h expected 3 deadbeef", a_cyc, a_rd); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        last_rd = 32'd0;
        test_reset();
        test_write_full();
        test_read();
        test_out_of_range();
        test_byte_enables();
        test_partial();
        test_back_to_back();
        test_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
